// File: rtl/data_mem_responder_if.sv
// Request/response bus between a requester and the data memory responder.
// The requester holds DataMem_access until it sees the single-cycle DataMem_Ready strobe.
interface data_mem_responder_if;
  logic        DataMem_access;
  logic        DataMem_RW;
  logic [3:0]  DataMem_Select;
  logic [31:0] DataMem_Address;
  logic [31:0] WriteDataMem;
  logic [31:0] ReadDataMem;
  logic        DataMem_Ready;
  logic        DataMem_Error;

  modport master (
    output DataMem_access, DataMem_RW, DataMem_Select, DataMem_Address, WriteDataMem,
    input  ReadDataMem, DataMem_Ready, DataMem_Error
  );

  modport slave (
    input  DataMem_access, DataMem_RW, DataMem_Select, DataMem_Address, WriteDataMem,
    output ReadDataMem, DataMem_Ready, DataMem_Error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory with byte enables and a fixed, parameterised response latency.
// Requests are captured in IDLE, wait LATENCY cycles, then answered in a single RESP cycle.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAST_WAIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state, state_next;
  logic [3:0]  wait_cnt;
  logic        cap_rw;
  logic [3:0]  cap_sel;
  logic [31:0] cap_addr, cap_wdata;
  logic [31:0] rdata;

  logic [31:0] mem [DEPTH];

  logic          start, wait_done, enter_resp;
  logic          eff_rw, eff_err, cap_err;
  logic [3:0]    eff_sel;
  logic [31:0]   eff_addr, eff_wdata, eff_mask;
  logic [AW-1:0] eff_idx;

  // With zero latency RESP is entered on the capture edge itself, so the live
  // request must be used there; otherwise the captured copy drives the access.
  always_comb begin
    start      = (state == IDLE) && bus.DataMem_access;
    wait_done  = (state == WAIT) && (wait_cnt == LAST_WAIT);
    enter_resp = rst && (((LATENCY == 0) && start) || wait_done);

    eff_rw    = (state == IDLE) ? bus.DataMem_RW      : cap_rw;
    eff_sel   = (state == IDLE) ? bus.DataMem_Select  : cap_sel;
    eff_addr  = (state == IDLE) ? bus.DataMem_Address : cap_addr;
    eff_wdata = (state == IDLE) ? bus.WriteDataMem    : cap_wdata;

    eff_err = (eff_addr[1:0] != 2'b00) || (eff_addr[31:AW+2] != '0);
    cap_err = (cap_addr[1:0] != 2'b00) || (cap_addr[31:AW+2] != '0);
    eff_idx = eff_addr[AW+1:2];

    eff_mask = '0;
    for (int i = 0; i < 4; i++) begin
      eff_mask[8*i +: 8] = {8{eff_sel[i]}};
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (wait_done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      cap_rw    <= 1'b0;
      cap_sel   <= 4'd0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      rdata     <= 32'd0;
    end else begin
      state <= state_next;
      if (start) begin
        cap_rw    <= bus.DataMem_RW;
        cap_sel   <= bus.DataMem_Select;
        cap_addr  <= bus.DataMem_Address;
        cap_wdata <= bus.WriteDataMem;
      end
      if (state == WAIT && !wait_done) wait_cnt <= wait_cnt + 4'd1;
      else                             wait_cnt <= 4'd0;
      // Write responses leave the read register untouched.
      if (enter_resp) begin
        if (eff_err)      rdata <= 32'd0;
        else if (!eff_rw) rdata <= mem[eff_idx] & eff_mask;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (enter_resp && eff_rw && !eff_err) begin
      for (int i = 0; i < 4; i++) begin
        if (eff_sel[i]) mem[eff_idx][8*i +: 8] <= eff_wdata[8*i +: 8];
      end
    end
  end

  assign bus.ReadDataMem   = rdata;
  assign bus.DataMem_Ready = (state == RESP);
  assign bus.DataMem_Error = (state == RESP) && cap_err;

endmodule
